// File: rtl/wb_commit_unit_if.sv
// Bundles the producer handshakes, decode issue/flush, register file write
// port and scoreboard of the writeback/commit stage.
interface wb_commit_unit_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) ();

  logic                         exu_valid;
  logic                         exu_ready;
  logic [ADDR_WIDTH-1:0]        exu_rd;
  logic [DATA_WIDTH-1:0]        exu_data;

  logic                         lsu_valid;
  logic                         lsu_ready;
  logic [ADDR_WIDTH-1:0]        lsu_rd;
  logic [DATA_WIDTH-1:0]        lsu_data;

  logic                         issue_valid;
  logic [ADDR_WIDTH-1:0]        issue_rd;
  logic                         flush;

  logic                         rf_wen;
  logic [ADDR_WIDTH-1:0]        rf_waddr;
  logic [DATA_WIDTH-1:0]        rf_wdata;
  logic [(2**ADDR_WIDTH)-1:0]   busy;
  logic [CNT_WIDTH-1:0]         retire_cnt;

  // Producers, decode and the register file sit on the master side.
  modport master (
    output exu_valid, exu_rd, exu_data,
    input  exu_ready,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    output issue_valid, issue_rd, flush,
    input  rf_wen, rf_waddr, rf_wdata, busy, retire_cnt
  );

  modport slave (
    input  exu_valid, exu_rd, exu_data,
    output exu_ready,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    input  issue_valid, issue_rd, flush,
    output rf_wen, rf_waddr, rf_wdata, busy, retire_cnt
  );

endinterface

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: round-robin arbitration between EXU and LSU results,
// a registered register-file write port, a busy scoreboard and a retire counter.
module wb_commit_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  wb_commit_unit_if.slave   bus
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  localparam logic [0:0] GRANT_EXU = 1'b0;
  localparam logic [0:0] GRANT_LSU = 1'b1;

  logic [0:0]            last_grant;
  logic                  grant_exu;
  logic                  grant_lsu;
  logic                  handshake;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_writes;

  logic                  rf_wen_q;
  logic [ADDR_WIDTH-1:0] rf_waddr_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;
  logic [CNT_WIDTH-1:0]  retire_q;

  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_next;
  logic [NUM_REGS-1:0]   set_mask;
  logic [NUM_REGS-1:0]   clear_mask;

  // Ready is held low during reset so no producer sees a result accepted
  // that the reset is about to discard.
  always_comb begin
    grant_exu = 1'b0;
    grant_lsu = 1'b0;
    if (!rst) begin
      if (bus.exu_valid && bus.lsu_valid) begin
        if (last_grant == GRANT_LSU) begin
          grant_exu = 1'b1;
        end else begin
          grant_lsu = 1'b1;
        end
      end else begin
        grant_exu = bus.exu_valid;
        grant_lsu = bus.lsu_valid;
      end
    end
  end

  always_comb begin
    handshake  = grant_exu | grant_lsu;
    sel_rd     = grant_lsu ? bus.lsu_rd   : bus.exu_rd;
    sel_data   = grant_lsu ? bus.lsu_data : bus.exu_data;
    sel_writes = handshake && (sel_rd != '0);
  end

  // Set is applied after clear so a re-issued destination stays busy.
  always_comb begin
    set_mask   = '0;
    clear_mask = '0;
    if (bus.issue_valid && (bus.issue_rd != '0)) begin
      set_mask[bus.issue_rd] = 1'b1;
    end
    if (sel_writes) begin
      clear_mask[sel_rd] = 1'b1;
    end
    if (bus.flush) begin
      busy_next = '0;
    end else begin
      busy_next = (busy_q & ~clear_mask) | set_mask;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_LSU;
    end else if (handshake) begin
      last_grant <= grant_lsu ? GRANT_LSU : GRANT_EXU;
    end
  end

  // Address and data hold between commits; only the enable is pulsed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_wen_q <= sel_writes;
      if (handshake) begin
        rf_waddr_q <= sel_rd;
        rf_wdata_q <= sel_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_q <= '0;
    end else if (handshake) begin
      retire_q <= retire_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

  assign bus.exu_ready  = grant_exu;
  assign bus.lsu_ready  = grant_lsu;
  assign bus.rf_wen     = rf_wen_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.busy       = busy_q;
  assign bus.retire_cnt = retire_q;

endmodule
